// File: rtl/morph_pkg.sv
// Shared geometry and FSM encoding for the morphology read/write/display paths.
package morph_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SYNC,
    ST_BACK,
    ST_ACTIVE,
    ST_FRONT
  } state_e;

  localparam int H_ACT_DEF   = 640;
  localparam int H_BLANK_DEF = 144;
  localparam int V_SYNC_DEF  = 3;
  localparam int V_BP_DEF    = 5;
  localparam int V_ACT_DEF   = 480;
  localparam int V_FP_DEF    = 2;

  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/morph_timing_cnt.sv
// Horizontal/vertical raster counters; h wraps each line, v advances at the wrap.
module morph_timing_cnt #(
  parameter int H_TOTAL = 784,
  parameter int H_W     = 10,
  parameter int V_W     = 9
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clr,
  input  logic           v_clr,
  output logic [H_W-1:0] h_cnt,
  output logic [V_W-1:0] v_cnt,
  output logic           line_end
);

  assign line_end = !clr && (h_cnt == H_W'(H_TOTAL - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (clr) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (line_end) begin
      h_cnt <= '0;
      v_cnt <= v_clr ? '0 : v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/morph_frame_reader.sv
// Pulls the eroded binary frame back from the SDRAM read FIFO and regenerates
// a camera-style href/vsync/pixel stream; starved slots are emitted as zero.
module morph_frame_reader
  import morph_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int H_ACT   = H_ACT_DEF,
  parameter int H_BLANK = H_BLANK_DEF,
  parameter int V_SYNC  = V_SYNC_DEF,
  parameter int V_BP    = V_BP_DEF,
  parameter int V_ACT   = V_ACT_DEF,
  parameter int V_FP    = V_FP_DEF
) (
  input  logic              module_clk,
  input  logic              module_rst_n,
  input  logic              frame_ready,
  input  logic              rd_empty,
  input  logic [DATA_W-1:0] rd_data,
  output logic              rd_load,
  output logic              rd_req,
  output logic              cam_href_r,
  output logic              cam_vsync_r,
  output logic              dout_val,
  output logic [7:0]        dout_8b,
  output logic              dout_1b,
  output logic              underflow,
  output logic              frame_done
);

  localparam int H_TOTAL = H_ACT + H_BLANK;
  localparam int H_W     = cnt_w(H_TOTAL);
  localparam int V_W     = cnt_w(V_SYNC + V_BP + V_ACT + V_FP);

  function automatic logic [7:0] binarize(input logic [7:0] px);
    return (|px) ? 8'hFF : 8'h00;
  endfunction

  state_e         state_q, state_d;
  logic [H_W-1:0] h_cnt;
  logic [V_W-1:0] v_cnt;
  logic           line_end, seg_end, cnt_clr, done_d;
  logic           slot_p0;
  logic           href_p1, req_p1, vsync_p1;
  logic           unused_hi;
  int             seg_lines;

  assign unused_hi = ^rd_data[DATA_W-1:8];
  assign cnt_clr   = (state_q == ST_IDLE) || (state_q == ST_LOAD);

  morph_timing_cnt #(
    .H_TOTAL (H_TOTAL),
    .H_W     (H_W),
    .V_W     (V_W)
  ) u_timing (
    .clk      (module_clk),
    .rst_n    (module_rst_n),
    .clr      (cnt_clr),
    .v_clr    (seg_end),
    .h_cnt    (h_cnt),
    .v_cnt    (v_cnt),
    .line_end (line_end)
  );

  always_ff @(posedge module_clk or negedge module_rst_n) begin
    if (!module_rst_n) state_q <= ST_IDLE;
    else               state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    seg_lines = 1;
    done_d    = 1'b0;
    unique case (state_q)
      ST_SYNC:   seg_lines = V_SYNC;
      ST_BACK:   seg_lines = V_BP;
      ST_ACTIVE: seg_lines = V_ACT;
      ST_FRONT:  seg_lines = V_FP;
      default:   seg_lines = 1;
    endcase
    seg_end = line_end && (v_cnt == V_W'(seg_lines - 1));
    unique case (state_q)
      ST_IDLE:   if (frame_ready) state_d = ST_LOAD;
      ST_LOAD:   state_d = ST_SYNC;
      ST_SYNC:   if (seg_end) state_d = ST_BACK;
      ST_BACK:   if (seg_end) state_d = ST_ACTIVE;
      ST_ACTIVE: if (seg_end) state_d = ST_FRONT;
      ST_FRONT:  if (seg_end) begin
                   state_d = ST_IDLE;
                   done_d  = 1'b1;
                 end
      default:   state_d = ST_IDLE;
    endcase
  end

  // p0: pixel slot decode and FIFO request in the current cycle
  assign slot_p0 = (state_q == ST_ACTIVE) && (h_cnt < H_W'(H_ACT));
  assign rd_req  = slot_p0 && !rd_empty;
  assign rd_load = (state_q == ST_LOAD);

  // p1: timing flags delayed one cycle to meet the FIFO read latency
  always_ff @(posedge module_clk or negedge module_rst_n) begin
    if (!module_rst_n) begin
      href_p1    <= 1'b0;
      req_p1     <= 1'b0;
      vsync_p1   <= 1'b0;
      frame_done <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      href_p1    <= slot_p0;
      req_p1     <= rd_req;
      vsync_p1   <= (state_q == ST_SYNC);
      frame_done <= done_d;
      if (state_q == ST_LOAD)       underflow <= 1'b0;
      else if (slot_p0 && rd_empty) underflow <= 1'b1;
    end
  end

  assign cam_href_r  = href_p1;
  assign dout_val    = href_p1;
  assign cam_vsync_r = vsync_p1;
  assign dout_8b     = req_p1 ? binarize(rd_data[7:0]) : 8'h00;
  assign dout_1b     = dout_8b[7];

endmodule

// File: tb/tb_morph_frame_reader.sv
// Directed bench for morph_frame_reader on a 6x5-cycle toy raster.
module tb_morph_frame_reader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        frame_ready;
  logic        rd_empty;
  logic [15:0] rd_data = 16'h0000;
  logic        rd_load, rd_req, cam_href_r, cam_vsync_r, dout_val, dout_1b;
  logic        underflow, frame_done;
  logic [7:0]  dout_8b;
  int          rd_idx = 0;

  int tests = 0;
  int fails = 0;

  // frame statistics collected by run_frame
  int          n_req, n_href, n_vs, vs_first, fd_cnt, fd_off, ld_cnt, ld_off;
  int          run, run_max, dv_bad;
  logic [63:0] pix;
  logic [7:0]  b1;
  logic        req_starve, uf_pre, uf_end;

  morph_frame_reader #(
    .H_ACT(4), .H_BLANK(2), .V_SYNC(1), .V_BP(1), .V_ACT(2), .V_FP(1)
  ) dut (
    .module_clk   (clk),
    .module_rst_n (rst_n),
    .frame_ready  (frame_ready),
    .rd_empty     (rd_empty),
    .rd_data      (rd_data),
    .rd_load      (rd_load),
    .rd_req       (rd_req),
    .cam_href_r   (cam_href_r),
    .cam_vsync_r  (cam_vsync_r),
    .dout_val     (dout_val),
    .dout_8b      (dout_8b),
    .dout_1b      (dout_1b),
    .underflow    (underflow),
    .frame_done   (frame_done)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] pat_of(input int i);
    case (i % 4)
      1:       return 8'h01;
      3:       return 8'hFF;
      default: return 8'h00;
    endcase
  endfunction

  // FIFO model: data appears one cycle after the request; upper byte is junk
  always @(posedge clk) begin
    if (rd_req) begin
      rd_data <= {8'hA5, pat_of(rd_idx)};
      rd_idx  <= rd_idx + 1;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_run(input int n, output int act);
    act = 0;
    repeat (n) begin
      tick();
      if (rd_load || rd_req || cam_href_r || cam_vsync_r) act++;
    end
  endtask

  // Runs 32 cycles from a LOAD cycle; starve_k selects a cycle with rd_empty=1
  task automatic run_frame(input int starve_k);
    n_req = 0; n_href = 0; n_vs = 0; vs_first = -1; fd_cnt = 0; fd_off = -1;
    ld_cnt = 0; ld_off = -1; run = 0; run_max = 0; dv_bad = 0;
    pix = '0; b1 = '0; req_starve = 1'bx; uf_pre = 1'bx; uf_end = 1'bx;
    for (int k = 1; k <= 32; k++) begin
      tick();
      rd_empty = (k == starve_k);
      #1;
      if (rd_req) n_req++;
      if (cam_href_r) begin
        n_href++;
        pix = {pix[55:0], dout_8b};
        b1  = {b1[6:0], dout_1b};
        if (dout_val !== 1'b1) dv_bad++;
        run++;
        if (run > run_max) run_max = run;
      end else begin
        run = 0;
      end
      if (cam_vsync_r) begin
        n_vs++;
        if (vs_first < 0) vs_first = k;
      end
      if (frame_done) begin fd_cnt++; fd_off = k; end
      if (rd_load)    begin ld_cnt++; ld_off = k; end
      if (k == starve_k) begin req_starve = rd_req; uf_pre = underflow; end
      if (k == 31) uf_end = underflow;
    end
    rd_empty = 1'b0;
  endtask

  int act;
  bit found;

  initial begin
    rst_n = 1'b0; frame_ready = 1'b0; rd_empty = 1'b0;
    tick(); tick();
    check("rst_outputs",
          {rd_load, rd_req, cam_href_r, cam_vsync_r, dout_val, dout_8b, dout_1b, underflow, frame_done},
          '0);
    rst_n = 1'b1;

    idle_run(40, act);
    check("idle_no_activity", act, 0);
    check("idle_underflow", underflow, 0);

    frame_ready = 1'b1;
    tick();
    check("load_pulse_first", rd_load, 1);

    run_frame(0);
    check("f1_rd_req_count", n_req, 8);
    check("f1_href_count", n_href, 8);
    check("f1_href_run", run_max, 4);
    check("f1_dout_val", dv_bad, 0);
    check("f1_pixels", pix, 64'h00FF00FF00FF00FF);
    check("f1_dout_1b", b1, 8'h55);
    check("f1_vsync_len", n_vs, 6);
    check("f1_vsync_first", vs_first, 2);
    check("f1_done_count", fd_cnt, 1);
    check("f1_done_cycle", fd_off, 31);
    check("f1_load_count", ld_cnt, 1);
    check("f1_next_load", ld_off, 32);
    check("f1_underflow", uf_end, 0);

    run_frame(15);
    check("f2_rd_req_count", n_req, 7);
    check("f2_starve_req", req_starve, 0);
    check("f2_uf_before", uf_pre, 0);
    check("f2_underflow", uf_end, 1);
    check("f2_href_count", n_href, 8);
    check("f2_href_run", run_max, 4);
    check("f2_pixels", pix, 64'h00FF0000FF00FF00);
    check("f2_dout_1b", b1, 8'h4A);
    check("f2_next_load", ld_off, 32);

    for (int k = 1; k <= 20; k++) begin
      tick();
      rd_empty = (k == 14);
      #1;
      if (k == 1) check("f3_uf_cleared", underflow, 0);
    end
    rd_empty = 1'b0;
    #1;
    check("f3_href_midline", cam_href_r, 1);
    check("f3_req_midline", rd_req, 1);
    check("f3_uf_set", underflow, 1);

    rst_n = 1'b0;
    frame_ready = 1'b0;
    #1;
    check("arst_outputs",
          {rd_load, rd_req, cam_href_r, cam_vsync_r, dout_val, dout_8b, dout_1b, underflow, frame_done},
          '0);
    tick(); tick();
    rst_n = 1'b1;

    idle_run(40, act);
    check("post_rst_idle", act, 0);

    frame_ready = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 5 && !found; i++) begin
      tick();
      if (rd_load) found = 1'b1;
      else if (i == 0) check("resample_load_latency", 0, 1);
    end
    check("resample_load", found, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/morph_frame_reader.md
# morph_frame_reader

Read-side counterpart of the morphology write path. The eroded binary frame is written to SDRAM by the erosion chain; this block pulls that frame back through the SDRAM read FIFO and regenerates a camera-style pixel stream (href/vsync/valid) for the downstream eye-tracking and display stages. It owns frame sequencing and FIFO read requests, and it replaces missing data with zeros on FIFO underflow.

## Interface
- H_ACT, 640, active pixels per line
- H_BLANK, 144, blank cycles after each active line (≥2)
- V_SYNC, 3, lines with vsync high at frame start
- V_BP, 5, blank lines after vsync
- V_ACT, 480, active lines
- V_FP, 2, blank lines after active region
- module_clk  in  1  pixel clock; all logic on rising edge
- module_rst_n  in  1  asynchronous, active-low reset
- frame_ready  in  1  level; a complete frame is available in SDRAM
- rd_empty  in  1  SDRAM read FIFO empty
- rd_data  in  16  FIFO data, valid one cycle after rd_req; pixel in [7:0]
- rd_load  out  1  one-cycle pulse; SDRAM controller reloads read address to frame base
- rd_req  out  1  FIFO read request
- cam_href_r  out  1  regenerated line-valid
- cam_vsync_r  out  1  regenerated frame sync, active high
- dout_val  out  1  pixel valid (equal to cam_href_r)
- dout_8b  out  8  pixel, 0x00 or 0xFF
- dout_1b  out  1  dout_8b[7]
- underflow  out  1  sticky; set on any starved pixel, cleared at next rd_load
- frame_done  out  1  one-cycle pulse at end of the last front-porch line

## Operation
- States: IDLE, LOAD, SYNC, BACK, ACTIVE, FRONT.
- IDLE: wait for frame_ready=1 → LOAD. frame_ready is sampled only in IDLE.
- LOAD: rd_load=1 for 1 cycle, underflow cleared → SYNC; h_cnt=v_cnt=0.
- h_cnt counts 0..H_ACT+H_BLANK-1 in every state except IDLE/LOAD; it wraps and v_cnt increments at the wrap.
- SYNC: vsync high for V_SYNC lines → BACK. BACK: V_BP lines → ACTIVE. ACTIVE: V_ACT lines → FRONT. FRONT: V_FP lines → frame_done pulse, then IDLE.
- v_cnt resets to 0 at each state change.
- ACTIVE, h_cnt<H_ACT: a pixel slot.
  - rd_empty=0 → rd_req=1.
  - rd_empty=1 → rd_req=0, underflow set, and that slot outputs 0x00.
- Output pixel: rd_data[7:0] when the slot issued rd_req, else 0x00. Non-zero data is forced to 0xFF (binary frame).
- Back-to-back frames: if frame_ready is still high on return to IDLE, LOAD follows on the next cycle.

## Timing
- Reset values: state IDLE; all outputs, counters and underflow 0.
- rd_req is combinational from state, h_cnt and rd_empty.
- Pixel outputs (cam_href_r, dout_val, dout_8b, dout_1b) are registered and aligned to rd_data: pixel slot at cycle t → outputs at t+1.
- cam_vsync_r is delayed by the same 1 cycle, so sync and data stay phase-aligned.
- Line period: H_ACT+H_BLANK cycles.
- Frame period: (V_SYNC+V_BP+V_ACT+V_FP)·(H_ACT+H_BLANK)+2 cycles, counting IDLE→LOAD→SYNC, when frame_ready is held high.
- Asynchronous reset mid-frame: immediate return to reset values. No rd_load is issued until the next frame_ready observed in IDLE.
- rd_empty toggling within a line affects only the slots where it is high. The pixel count per line stays H_ACT.

## Structure
- Shared package (morph_pkg): state enum and default timing constants, so the writer and display modules use the same geometry.
- One sub-module, morph_timing_cnt: h/v counters with wrap and line-end strobes, reused by the display path. FSM, read control and output registers stay in the top.

## Test plan
- Small geometry H_ACT=4, H_BLANK=2, V_SYNC=1, V_BP=1, V_ACT=2, V_FP=1. frame_ready=1, FIFO full with 0x00,0x01,0x00,0xFF,... → rd_load 1 pulse; 8 rd_req; dout_8b 00,FF,00,FF per line; frame_done at cycle 32.
- Same geometry, frame_ready held 1 → second rd_load exactly 32 cycles after the first; no extra idle.
- rd_empty=1 during the 3rd slot of line 0 → rd_req low in that slot, pixel 0x00, underflow=1. Href pulse is still 4 cycles. The next rd_load clears underflow.
- module_rst_n pulsed low during ACTIVE line 1 → all outputs 0 immediately; no rd_load until frame_ready is re-sampled in IDLE.
- frame_ready=0 → block stays in IDLE indefinitely; rd_req, rd_load, href and vsync remain 0.
- Default geometry, one frame → 480 href pulses of 640 valid cycles each. Vsync high for 3·784 cycles.
